// File: rtl/yfuzz_pkg.sv
// Shared constants and types for the y-bus signature compactor and the
// upstream stimulus checker.
//   Y_W   : width of the y bus produced by the design under test
//   SIG_W : MISR signature width
//   POLY  : MISR feedback polynomial
//   SEED  : signature value loaded when a run starts
//   state_t : compactor run state (IDLE / RUN / DONE)
package yfuzz_pkg;

  localparam int          Y_W   = 242;
  localparam int          SIG_W = 32;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/y_signature_compactor_if.sv
// Bus between the producer of y samples and the signature compactor.
//   start, y_valid, y, expected_sig : driven by the producer (master)
//   busy, sig, sample_cnt, toggle_cnt, done, match : driven by the compactor (slave)
interface y_signature_compactor_if;
  import yfuzz_pkg::*;

  logic             start;
  logic             y_valid;
  logic [Y_W-1:0]   y;
  logic [SIG_W-1:0] expected_sig;
  logic             busy;
  logic [SIG_W-1:0] sig;
  logic [15:0]      sample_cnt;
  logic [15:0]      toggle_cnt;
  logic             done;
  logic             match;

  modport master (
    output start, y_valid, y, expected_sig,
    input  busy, sig, sample_cnt, toggle_cnt, done, match
  );

  modport slave (
    input  start, y_valid, y, expected_sig,
    output busy, sig, sample_cnt, toggle_cnt, done, match
  );

endinterface

// File: rtl/y_fold_xor.sv
// Purely combinational fold of a wide bus down to one signature-width word.
// The input is cut into OUT_W-bit chunks (the top chunk zero-padded above
// the last input bit) and all chunks are XORed together.
//   y    : IN_W-bit input bus
//   fold : OUT_W-bit XOR of all chunks
module y_fold_xor
  import yfuzz_pkg::*;
#(
  parameter int IN_W  = Y_W,
  parameter int OUT_W = SIG_W
) (
  input  logic [IN_W-1:0]  y,
  output logic [OUT_W-1:0] fold
);

  localparam int CHUNKS = (IN_W + OUT_W - 1) / OUT_W;

  logic [CHUNKS*OUT_W-1:0] padded;

  always_comb begin
    padded           = '0;
    padded[IN_W-1:0] = y;
    fold             = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      fold = fold ^ padded[k*OUT_W +: OUT_W];
    end
  end

endmodule

// File: rtl/y_signature_compactor.sv
// Compresses accepted y samples into a 32-bit MISR signature, counts
// accepted samples and samples that differ from the previous accepted one,
// and after NUM_SAMPLES samples compares the signature with a golden value.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of y_signature_compactor_if
//              (start, y_valid, y, expected_sig in;
//               busy, sig, sample_cnt, toggle_cnt, done, match out)
module y_signature_compactor
  import yfuzz_pkg::*;
#(
  parameter int NUM_SAMPLES = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  y_signature_compactor_if.slave  bus
);

  state_t           state, state_next;
  logic [SIG_W-1:0] sig_q, fold, sig_next;
  logic [Y_W-1:0]   prev_y;
  logic [15:0]      sample_cnt_q, toggle_cnt_q;
  logic             match_q;
  logic             busy, done;
  logic             accept, last_sample;

  y_fold_xor #(.IN_W(Y_W), .OUT_W(SIG_W)) u_fold (
    .y    (bus.y),
    .fold (fold)
  );

  assign sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;

  // A start in RUN aborts the run, so that cycle's sample is never accepted.
  assign accept      = (state == RUN) && bus.y_valid && !bus.start;
  assign last_sample = accept && (sample_cnt_q == 16'(NUM_SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (bus.start) state_next = RUN;
               else if (last_sample) state_next = DONE;
      DONE:    if (bus.start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: a start from any state reloads the seed and clears the
  // counters; otherwise state only moves on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q        <= SEED;
      prev_y       <= '0;
      sample_cnt_q <= '0;
      toggle_cnt_q <= '0;
      match_q      <= 1'b0;
    end else if (bus.start) begin
      sig_q        <= SEED;
      prev_y       <= '0;
      sample_cnt_q <= '0;
      toggle_cnt_q <= '0;
      match_q      <= 1'b0;
    end else if (accept) begin
      sig_q  <= sig_next;
      prev_y <= bus.y;
      if (sample_cnt_q != 16'hFFFF) sample_cnt_q <= sample_cnt_q + 16'd1;
      if ((bus.y != prev_y) && (toggle_cnt_q != 16'hFFFF)) toggle_cnt_q <= toggle_cnt_q + 16'd1;
      if (last_sample) match_q <= (sig_next == bus.expected_sig);
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.sig        = sig_q;
  assign bus.sample_cnt = sample_cnt_q;
  assign bus.toggle_cnt = toggle_cnt_q;
  assign bus.match      = match_q;

endmodule

// File: tb/tb_y_signature_compactor.sv
// Self-checking bench for y_signature_compactor. Three instances with
// NUM_SAMPLES = 1, 3 and 21 share the clock and reset; `sel` picks which one
// the directed stimulus drives and observes. Expected results come from an
// independent bit-level model and are queued in a scoreboard when a run is
// driven, then popped and compared when the DUT reports done.
module tb_y_signature_compactor;
  import yfuzz_pkg::*;

  typedef struct {
    logic [31:0] sig;
    logic [15:0] scnt;
    logic [15:0] tcnt;
    logic        match;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int          sel;
  logic        start_d, valid_d;
  logic [241:0] y_d;
  logic [31:0] exp_d;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];

  y_signature_compactor_if if1 ();
  y_signature_compactor_if if3 ();
  y_signature_compactor_if if21 ();

  y_signature_compactor #(.NUM_SAMPLES(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  y_signature_compactor #(.NUM_SAMPLES(3))  dut3  (.clk(clk), .rst(rst), .bus(if3));
  y_signature_compactor #(.NUM_SAMPLES(21)) dut21 (.clk(clk), .rst(rst), .bus(if21));

  assign if1.start   = start_d && (sel == 0);
  assign if3.start   = start_d && (sel == 1);
  assign if21.start  = start_d && (sel == 2);
  assign if1.y_valid  = valid_d && (sel == 0);
  assign if3.y_valid  = valid_d && (sel == 1);
  assign if21.y_valid = valid_d && (sel == 2);
  assign if1.y  = y_d;
  assign if3.y  = y_d;
  assign if21.y = y_d;
  assign if1.expected_sig  = exp_d;
  assign if3.expected_sig  = exp_d;
  assign if21.expected_sig = exp_d;

  logic [31:0] o_sig;
  logic [15:0] o_scnt, o_tcnt;
  logic        o_busy, o_done, o_match;

  always_comb begin
    o_sig = if1.sig; o_scnt = if1.sample_cnt; o_tcnt = if1.toggle_cnt;
    o_busy = if1.busy; o_done = if1.done; o_match = if1.match;
    if (sel == 1) begin
      o_sig = if3.sig; o_scnt = if3.sample_cnt; o_tcnt = if3.toggle_cnt;
      o_busy = if3.busy; o_done = if3.done; o_match = if3.match;
    end else if (sel == 2) begin
      o_sig = if21.sig; o_scnt = if21.sample_cnt; o_tcnt = if21.toggle_cnt;
      o_busy = if21.busy; o_done = if21.done; o_match = if21.match;
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge that consumed it.
  task automatic apply_stimulus(input logic st, input logic v, input logic [241:0] yv);
    start_d = st;
    valid_d = v;
    y_d     = yv;
    @(posedge clk);
    #1;
    start_d = 1'b0;
    valid_d = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: every input bit i lands on signature bit i mod 32.
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [241:0] v);
    logic [31:0] f;
    logic [31:0] n;
    f = '0;
    for (int i = 0; i < 242; i++) f[i % 32] = f[i % 32] ^ v[i];
    n = s << 1;
    if (s[31]) n = n ^ 32'h04C11DB7;
    return n ^ f;
  endfunction

  function automatic exp_t model_run(input logic [241:0] s[$], input logic [31:0] golden);
    exp_t r;
    logic [241:0] prev;
    r.sig = 32'hFFFFFFFF;
    r.tcnt = '0;
    prev = '0;
    foreach (s[i]) begin
      r.sig = model_step(r.sig, s[i]);
      if (s[i] !== prev) r.tcnt = r.tcnt + 16'd1;
      prev = s[i];
    end
    r.scnt  = 16'(s.size());
    r.match = (r.sig == golden);
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    check_output({tag, " busy"}, 32'(o_busy), 32'd0);
    check_output({tag, " done"}, 32'(o_done), 32'd0);
    check_output({tag, " sig"},  o_sig, 32'hFFFFFFFF);
    check_output({tag, " scnt"}, 32'(o_scnt), 32'd0);
    check_output({tag, " tcnt"}, 32'(o_tcnt), 32'd0);
  endtask

  task automatic pop_and_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_output({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check_output({tag, " done"},  32'(o_done), 32'd1);
    check_output({tag, " busy"},  32'(o_busy), 32'd0);
    check_output({tag, " sig"},   o_sig, e.sig);
    check_output({tag, " scnt"},  32'(o_scnt), 32'(e.scnt));
    check_output({tag, " tcnt"},  32'(o_tcnt), 32'(e.tcnt));
    check_output({tag, " match"}, 32'(o_match), 32'(e.match));
  endtask

  // Gap-free run; done must appear exactly after the last sample.
  task automatic run_and_check(input string tag, input logic [241:0] s[$],
                               input logic [31:0] golden, input bit do_start);
    sb_q.push_back(model_run(s, golden));
    exp_d = golden;
    if (do_start) begin
      apply_stimulus(1'b1, 1'b0, '0);
      check_output({tag, " busy after start"}, 32'(o_busy), 32'd1);
    end
    foreach (s[i]) begin
      if (i == s.size() - 1) check_output({tag, " done early"}, 32'(o_done), 32'd0);
      apply_stimulus(1'b0, 1'b1, s[i]);
    end
    pop_and_compare(tag);
  endtask

  logic [241:0] vecs[21];
  logic [241:0] q[$];
  logic [241:0] one_hot, va, vb;
  logic [255:0] tmp;
  logic [31:0]  held_sig;
  exp_t         e_gap;

  initial begin
    sel = 0; start_d = 0; valid_d = 0; y_d = '0; exp_d = '0;
    for (int n = 0; n < 21; n++) begin
      for (int k = 0; k < 8; k++) tmp[k*32 +: 32] = $urandom;
      vecs[n] = tmp[241:0];
    end

    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, '0);
    rst = 1'b0;
    check_reset_values("reset");
    check_output("reset match", 32'(o_match), 32'd0);

    // NUM_SAMPLES = 1: known signatures
    sel = 0;
    q = '{242'd0};
    run_and_check("n1 zero", q, 32'hFB3EE249, 1'b1);
    check_output("n1 zero const", o_sig, 32'hFB3EE249);
    q = '{242'd0};
    run_and_check("n1 zero nomatch", q, 32'h00000000, 1'b1);

    held_sig = o_sig;
    apply_stimulus(1'b0, 1'b1, vecs[0]);
    apply_stimulus(1'b0, 1'b1, vecs[1]);
    check_output("done hold sig", o_sig, held_sig);
    check_output("done hold scnt", 32'(o_scnt), 32'd1);
    check_output("done hold done", 32'(o_done), 32'd1);

    one_hot = '0; one_hot[0] = 1'b1;
    q = '{one_hot};
    run_and_check("n1 bit0", q, 32'hFB3EE248, 1'b1);
    check_output("n1 bit0 const", o_sig, 32'hFB3EE248);
    one_hot = '0; one_hot[32] = 1'b1;
    q = '{one_hot};
    run_and_check("n1 bit32", q, 32'hFB3EE248, 1'b1);
    check_output("n1 bit32 const", o_sig, 32'hFB3EE248);
    check_output("n1 bit32 tcnt", 32'(o_tcnt), 32'd1);
    one_hot = '0; one_hot[241] = 1'b1;
    q = '{one_hot};
    run_and_check("n1 bit241", q, 32'hFB3CE249, 1'b1);
    check_output("n1 bit241 const", o_sig, 32'hFB3CE249);

    // NUM_SAMPLES = 3 with gaps: A,junk,junk,A,B
    sel = 1;
    va = vecs[2];
    vb = vecs[3];
    q = '{va, va, vb};
    e_gap = model_run(q, 32'h0);
    sb_q.push_back(model_run(q, e_gap.sig));
    exp_d = e_gap.sig;
    apply_stimulus(1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, va);
    held_sig = model_step(32'hFFFFFFFF, va);
    apply_stimulus(1'b0, 1'b0, vecs[4]);
    apply_stimulus(1'b0, 1'b0, vecs[5]);
    check_output("gap sig held", o_sig, held_sig);
    check_output("gap scnt held", 32'(o_scnt), 32'd1);
    apply_stimulus(1'b0, 1'b1, va);
    check_output("gap tcnt repeat", 32'(o_tcnt), 32'd1);
    apply_stimulus(1'b0, 1'b1, vb);
    pop_and_compare("n3 gap");
    check_output("n3 gap tcnt", 32'(o_tcnt), 32'd2);

    // NUM_SAMPLES = 21: two identical runs, second against the model value
    sel = 2;
    q = {};
    for (int n = 0; n < 21; n++) q.push_back(vecs[n]);
    e_gap = model_run(q, 32'h0);
    run_and_check("n21 run1", q, 32'h0, 1'b1);
    run_and_check("n21 run2", q, e_gap.sig, 1'b1);

    // Abort with start on the 5th sample, then a clean run from there
    exp_d = e_gap.sig;
    apply_stimulus(1'b1, 1'b0, '0);
    for (int n = 0; n < 4; n++) apply_stimulus(1'b0, 1'b1, vecs[n]);
    check_output("abort pre scnt", 32'(o_scnt), 32'd4);
    apply_stimulus(1'b1, 1'b1, vecs[4]);
    check_output("abort scnt", 32'(o_scnt), 32'd0);
    check_output("abort tcnt", 32'(o_tcnt), 32'd0);
    check_output("abort sig", o_sig, 32'hFFFFFFFF);
    check_output("abort busy", 32'(o_busy), 32'd1);
    run_and_check("n21 after abort", q, e_gap.sig, 1'b0);

    // Reset on the 10th sample, then a normal run
    apply_stimulus(1'b1, 1'b0, '0);
    for (int n = 0; n < 9; n++) apply_stimulus(1'b0, 1'b1, vecs[n]);
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b1, vecs[9]);
    rst = 1'b0;
    check_reset_values("midrun reset");
    run_and_check("n21 after reset", q, e_gap.sig, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/y_signature_compactor.md
Name: y_signature_compactor

Overview:
- Downstream consumer of the 242-bit `y` output of the fuzzed `top` design.
- Compresses one accepted `y` sample per cycle into a 32-bit MISR signature, so differential runs compare one word instead of a per-cycle `$strobe` dump.
- Counts accepted samples and samples where `y` changed.
- After NUM_SAMPLES samples, compares the signature with an expected value and raises done/match.

Parameters:
- Y_W, 242, width of the `y` bus under test.
- SIG_W, 32, signature width.
- NUM_SAMPLES, 21, accepted samples per run; legal range 1..2^16-1.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, signature value loaded on `start`.

Ports:
- clk  in  1  rising-edge clock, shared with `top`.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run.
- y_valid  in  1  `y` holds a sample to accept this cycle.
- y  in  Y_W  output bus of the design under test.
- expected_sig  in  SIG_W  golden signature; sampled only on the cycle the run finishes.
- busy  out  1  run in progress.
- sig  out  SIG_W  current signature.
- sample_cnt  out  16  samples accepted in the current run.
- toggle_cnt  out  16  accepted samples that differed from the previous accepted sample.
- done  out  1  run complete; sticky until the next start or reset.
- match  out  1  valid when done=1; 1 if sig == expected_sig.

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - Reset is synchronous and active-high.
  - Reset has priority over all other inputs.
  - Reset values: sig=SEED, sample_cnt=0, toggle_cnt=0, busy=0, done=0, match=0; prev_y register = 0; state=IDLE.
- Fold (combinational):
  - Split `y` into ceil(Y_W/32) = 8 chunks; chunk k = y[32k+31:32k].
  - The top chunk is zero-padded above bit Y_W-1.
  - fold = XOR of all chunks.
- MISR step: sig_next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold.
- States IDLE, RUN, DONE:
  - IDLE: y_valid ignored; outputs hold.
    - start → RUN; load sig=SEED and prev_y=0; clear both counters, done and match.
  - RUN: busy=1. On each cycle with y_valid=1:
    - sig <= sig_next; sample_cnt += 1.
    - toggle_cnt += (y != prev_y); prev_y <= y.
    - If this is sample NUM_SAMPLES: go to DONE on the next edge, with done=1 and match=(sig_next == expected_sig), compared the same cycle.
  - Accept timing:
    - Samples are accepted on the same edge on which y_valid is seen; latency from the accepted sample to the sig update is 1 cycle.
    - y_valid=0 in RUN holds all state (gaps allowed).
  - DONE: busy=0, done=1; sig, match and counters frozen; y_valid ignored.
    - start → RUN with a fresh reload, exactly as from IDLE.
- start while in RUN: abort and restart. Reload SEED and clear counters; the y sample presented in that cycle is NOT accepted.
- Counters: 16-bit saturating. Cannot wrap within the legal NUM_SAMPLES range; saturate regardless.
- Reset mid-run returns to IDLE with the reset values; no done pulse.
- No X handling in the block; the bench must not drive X on `y` while y_valid=1.

Decomposition:
- Shared package `yfuzz_pkg`:
  - Y_W, SIG_W, POLY, SEED constants.
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module `y_fold_xor` (pure combinational: Y_W in, SIG_W out, zero-pad, XOR tree). It is reused by the upstream stimulus checker.
- FSM, MISR and counters stay in the top module.

Test Plan:
- NUM_SAMPLES=1; reset, start, one sample y=0 → next cycle sig=32'hFB3EE249, sample_cnt=1, toggle_cnt=0, done=1; match=1 iff expected_sig=32'hFB3EE249.
- NUM_SAMPLES=1; y=1, then a separate run with y=1<<32 → both runs give sig=32'hFB3EE248, toggle_cnt=1 (fold aliasing check). A run with y=1<<241 gives sig=32'hFB3CE249 (top-chunk padding check).
- NUM_SAMPLES=3; y_valid pattern 1,0,0,1,1 with y=A,X-free junk,junk,A,B → sample_cnt=3, and sig equals the value from a gap-free run of A,A,B; toggle_cnt=2.
- NUM_SAMPLES=21; drive the 21 fuzz input vectors through `top` with y_valid=1 every cycle → done after exactly 21 accepted cycles. Run twice with identical stimulus: same sig both times, match=1 against the first-run value.
- start asserted at sample 5 of a run → counters restart at 0, that cycle's sample not counted, and the final sig equals a clean run.
- rst asserted at sample 10 → next cycle busy=0, done=0, sig=32'hFFFFFFFF, counters 0. A later start runs normally.
